// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and channel state encoding for multi_tick_gen
//
// Purpose: mode encodings and the per-channel FSM state type used by
//          tick_channel and multi_tick_gen.
// Ports:   none (package).
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable tick channel (counter, FSM, shadow/active divisor)
//
// Purpose: generates one-cycle tick enables every D+1 cycles (periodic) or a
//          single tick per start (one-shot). Divisor writes land in a shadow
//          register and reach the active divisor only while idle or at
//          terminal count, so a running period is never cut or stretched.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low
//   start     in   start pulse (ignored while running)
//   stop      in   stop pulse (wins over start and sync_clr)
//   mode      in   0 = periodic, 1 = one-shot; latched at start
//   wr        in   shadow divisor write strobe
//   data      in   divisor value D
//   sync_clr  in   clear counter of a running channel
//   tick      out  registered one-cycle enable
//   tick_nxt  out  next-state tick, for the top-level registered OR
//   busy      out  channel is in RUN
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W       = 27,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(49999999)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             wr,
  input  logic [CNT_W-1:0] data,
  input  logic             sync_clr,
  output logic             tick,
  output logic             tick_nxt,
  output logic             busy
);

  ch_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_div_active, w_div_active_nxt;
  logic [CNT_W-1:0] r_div_shadow, w_div_shadow_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tick, w_tick_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_div_active <= DEFAULT_DIV;
      r_div_shadow <= DEFAULT_DIV;
      r_mode       <= MODE_PERIODIC;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_div_active <= w_div_active_nxt;
      r_div_shadow <= w_div_shadow_nxt;
      r_mode       <= w_mode_nxt;
      r_tick       <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_div_active_nxt = r_div_active;
    w_div_shadow_nxt = wr ? data : r_div_shadow;
    w_mode_nxt       = r_mode;
    w_tick_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt        = '0;
        // Idle channels track the shadow so a write takes effect one cycle later.
        w_div_active_nxt = r_div_shadow;
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_mode_nxt  = mode;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (sync_clr) begin
          // Suppresses a terminal count falling in this cycle.
          w_cnt_nxt = '0;
        end else if (r_cnt == r_div_active) begin
          w_cnt_nxt        = '0;
          w_tick_nxt       = 1'b1;
          // Registered shadow: a write in this same cycle waits one more period.
          w_div_active_nxt = r_div_shadow;
          if (r_mode == MODE_ONESHOT) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign tick     = r_tick;
  assign tick_nxt = w_tick_nxt;
  assign busy     = (r_state == ST_RUN);

endmodule

// File: rtl/multi_tick_gen.sv
// rtl/multi_tick_gen.sv - multi-channel runtime-programmable tick enable generator
//
// Purpose: NUM_CH independent tick_channel instances with a shared divisor
//          write port and a global phase-align clear. Ticks are clock enables.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low
//   start     in   [NUM_CH] per-channel start pulse
//   stop      in   [NUM_CH] per-channel stop pulse
//   mode      in   [NUM_CH] 0 = periodic, 1 = one-shot, sampled at start
//   div_wr    in   divisor write strobe
//   div_ch    in   [IDX_W] channel addressed by div_wr (out-of-range ignored)
//   div_data  in   [CNT_W] divisor D, period D+1 cycles
//   sync_clr  in   clear counters of all running channels
//   tick      out  [NUM_CH] registered one-cycle enables
//   busy      out  [NUM_CH] channel running
//   tick_any  out  registered OR of tick, aligned with tick
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 49999999,
  parameter int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] mode,
  input  logic              div_wr,
  input  logic [IDX_W-1:0]  div_ch,
  input  logic [CNT_W-1:0]  div_data,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy,
  output logic              tick_any
);

  logic [NUM_CH-1:0] w_tick_nxt;
  logic              r_tick_any;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wr;
    // Indices >= NUM_CH never match, so such writes touch nothing.
    assign w_wr = div_wr && (div_ch == IDX_W'(g));

    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .stop     (stop[g]),
      .mode     (mode[g]),
      .wr       (w_wr),
      .data     (div_data),
      .sync_clr (sync_clr),
      .tick     (tick[g]),
      .tick_nxt (w_tick_nxt[g]),
      .busy     (busy[g])
    );
  end

  // Built from next-state ticks so it lands in the same cycle as tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tick_any <= 1'b0;
    end else begin
      r_tick_any <= |w_tick_nxt;
    end
  end

  assign tick_any = r_tick_any;

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb/tb_multi_tick_gen.sv - scoreboard bench for multi_tick_gen
module tb_multi_tick_gen;

  localparam int NCH  = 5;
  localparam int CW   = 27;
  localparam int DDEF = 20;
  localparam int IW   = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] start, stop, mode;
  logic           div_wr;
  logic [IW-1:0]  div_ch;
  logic [CW-1:0]  div_data;
  logic           sync_clr;
  logic [NCH-1:0] tick, busy;
  logic           tick_any;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] mask;
  } exp_t;
  exp_t exp_q[$];

  multi_tick_gen #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDEF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_data (div_data),
    .sync_clr (sync_clr),
    .tick     (tick),
    .busy     (busy),
    .tick_any (tick_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(int c, logic [NCH-1:0] m);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == c) begin
        exp_q[i].mask = exp_q[i].mask | m;
        return;
      end
      if (exp_q[i].cyc > c) begin
        exp_q.insert(i, '{cyc: c, mask: m});
        return;
      end
    end
    exp_q.push_back('{cyc: c, mask: m});
  endfunction

  function automatic logic [NCH-1:0] pop_exp(int c);
    logic [NCH-1:0] m;
    m = '0;
    if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
      m = exp_q[0].mask;
      void'(exp_q.pop_front());
    end
    return m;
  endfunction

  task automatic idle_inputs();
    start    = '0;
    stop     = '0;
    div_wr   = 1'b0;
    div_ch   = '0;
    div_data = '0;
    sync_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mode  = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    mode  = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (tick !== '0) begin errors++; $display("FAIL reset_tick got=%b exp=%b", tick, 5'b0); end
    if (busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=%b", busy, 5'b0); end
    if (tick_any !== 1'b0) begin errors++; $display("FAIL reset_tick_any got=%b exp=0", tick_any); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (tick !== '0) begin errors++; $display("FAIL idle_tick k=%0d got=%b exp=%b", k, tick, 5'b0); end
      if (busy !== '0) begin errors++; $display("FAIL idle_busy k=%0d got=%b exp=%b", k, busy, 5'b0); end
      @(posedge clk); #1;
    end
  endtask

  // ch0 periodic D=4: ticks at +8,+13,+18,+23 after a start at +2.
  task automatic test_periodic();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 8, 5'b00001);
    push_exp(base + 13, 5'b00001);
    push_exp(base + 18, 5'b00001);
    push_exp(base + 23, 5'b00001);
    for (int k = 0; k < 29; k++) begin
      idle_inputs();
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd4; end
      if (k == 2) begin start[0] = 1'b1; mode[0] = 1'b0; end
      if (k == 24) stop[0] = 1'b1;
      eb = (k >= 3 && k <= 24) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 3;
      if (tick !== em) begin errors++; $display("FAIL periodic_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (tick_any !== (|em)) begin errors++; $display("FAIL periodic_tick_any k=%0d got=%b exp=%b", k, tick_any, |em); end
      if (busy !== eb) begin errors++; $display("FAIL periodic_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_missing got=%0d exp=0", exp_q.size()); end
  endtask

  // ch1 one-shot D=2 and ch2 periodic D=0, both started at +3.
  task automatic test_oneshot();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 7, 5'b00010);
    for (int c = 5; c <= 9; c++) push_exp(base + c, 5'b00100);
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd1; div_data = 27'd2; end
      if (k == 1) begin div_wr = 1'b1; div_ch = 3'd2; div_data = 27'd0; end
      if (k == 3) begin start = 5'b00110; mode = 5'b00010; end
      if (k == 6) start[2] = 1'b1;
      if (k == 9) stop[2] = 1'b1;
      eb = '0;
      if (k >= 4 && k <= 6) eb[1] = 1'b1;
      if (k >= 4 && k <= 9) eb[2] = 1'b1;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 3;
      if (tick !== em) begin errors++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (tick_any !== (|em)) begin errors++; $display("FAIL oneshot_tick_any k=%0d got=%b exp=%b", k, tick_any, |em); end
      if (busy !== eb) begin errors++; $display("FAIL oneshot_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_missing got=%0d exp=0", exp_q.size()); end
  endtask

  // D 4 -> 9 mid-period, then 9 -> 2 written exactly at terminal count.
  task automatic test_div_update();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 8, 5'b00001);
    push_exp(base + 13, 5'b00001);
    push_exp(base + 23, 5'b00001);
    push_exp(base + 33, 5'b00001);
    push_exp(base + 43, 5'b00001);
    push_exp(base + 46, 5'b00001);
    push_exp(base + 49, 5'b00001);
    for (int k = 0; k < 54; k++) begin
      idle_inputs();
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd4; end
      if (k == 2) begin start[0] = 1'b1; mode[0] = 1'b0; end
      if (k == 10) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd9; end
      if (k == 32) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd2; end
      if (k == 50) stop[0] = 1'b1;
      eb = (k >= 3 && k <= 50) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 2;
      if (tick !== em) begin errors++; $display("FAIL divupd_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (busy !== eb) begin errors++; $display("FAIL divupd_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL divupd_missing got=%0d exp=0", exp_q.size()); end
  endtask

  // ch0/ch2 D=3 started 2 cycles apart; sync_clr lands on ch2's terminal count.
  task automatic test_sync_clr();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 8, 5'b00001);
    push_exp(base + 12, 5'b00001);
    push_exp(base + 16, 5'b00001);
    push_exp(base + 10, 5'b00100);
    push_exp(base + 14, 5'b00100);
    push_exp(base + 22, 5'b00101);
    push_exp(base + 26, 5'b00101);
    push_exp(base + 30, 5'b00101);
    for (int k = 0; k < 35; k++) begin
      idle_inputs();
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd3; end
      if (k == 1) begin div_wr = 1'b1; div_ch = 3'd2; div_data = 27'd3; end
      if (k == 3) begin start[0] = 1'b1; mode = '0; end
      if (k == 5) start[2] = 1'b1;
      if (k == 17) sync_clr = 1'b1;
      if (k == 31) stop = 5'b00101;
      eb = '0;
      if (k >= 4 && k <= 31) eb[0] = 1'b1;
      if (k >= 6 && k <= 31) eb[2] = 1'b1;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 3;
      if (tick !== em) begin errors++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (tick_any !== (|em)) begin errors++; $display("FAIL sync_tick_any k=%0d got=%b exp=%b", k, tick_any, |em); end
      if (busy !== eb) begin errors++; $display("FAIL sync_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sync_missing got=%0d exp=0", exp_q.size()); end
  endtask

  // Out-of-range write must not disturb any channel; start+stop on ch3 stays idle.
  task automatic test_start_stop_invalid();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 2 + 2 + DDEF, 5'b00011);
    for (int k = 0; k < 28; k++) begin
      idle_inputs();
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd5; div_data = 27'd2; end
      if (k == 2) begin start = 5'b01011; stop = 5'b01000; mode = 5'b00011; end
      eb = (k >= 3 && k <= 2 + 1 + DDEF) ? 5'b00011 : 5'b00000;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 2;
      if (tick !== em) begin errors++; $display("FAIL ss_inv_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (busy !== eb) begin errors++; $display("FAIL ss_inv_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ss_inv_missing got=%0d exp=0", exp_q.size()); end
  endtask

  // Reset pulse mid-count with a pending shadow write; restart sees DEFAULT_DIV.
  task automatic test_reset_mid();
    int base;
    logic [NCH-1:0] em, eb;
    do_reset();
    base = cyc;
    push_exp(base + 8, 5'b00001);
    push_exp(base + 13, 5'b00001);
    push_exp(base + 20 + 2 + DDEF, 5'b00001);
    for (int k = 0; k < 46; k++) begin
      idle_inputs();
      reset = (k == 15) ? 1'b0 : 1'b1;
      if (k == 0) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd4; end
      if (k == 2) begin start[0] = 1'b1; mode[0] = 1'b0; end
      if (k == 14) begin div_wr = 1'b1; div_ch = 3'd0; div_data = 27'd1; end
      if (k == 20) begin start[0] = 1'b1; mode[0] = 1'b1; end
      eb = ((k >= 3 && k <= 15) || (k >= 21 && k <= 20 + 1 + DDEF)) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      em = pop_exp(cyc);
      checks += 3;
      if (tick !== em) begin errors++; $display("FAIL rstmid_tick k=%0d got=%b exp=%b", k, tick, em); end
      if (tick_any !== (|em)) begin errors++; $display("FAIL rstmid_tick_any k=%0d got=%b exp=%b", k, tick_any, |em); end
      if (busy !== eb) begin errors++; $display("FAIL rstmid_busy k=%0d got=%b exp=%b", k, busy, eb); end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    idle_inputs();
    mode  = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_div_update();
    test_sync_clr();
    test_start_stop_invalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
